// File: rtl/sincere_pkg.sv
// Shared definitions for the fetch path.
// Holds the opcode constants, the field layout of the 46-bit program line
// {addr[3:0], mode[1:0], opcode[3:0], op_a[11:0], op_b[11:0], op_c[11:0]}
// and the fetch FSM state encoding.
package sincere_pkg;

  // Opcodes
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_MOV = 4'h1;
  localparam logic [3:0] OP_JMP = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h5;
  localparam logic [3:0] OP_SUB = 4'h6;
  localparam logic [3:0] OP_MUL = 4'h7;
  localparam logic [3:0] OP_NOT = 4'h8;

  // Line field offsets (LSB position) and widths
  localparam int LINE_BITS    = 46;
  localparam int F_ADDR_LSB   = 42;
  localparam int F_ADDR_W     = 4;
  localparam int F_MODE_LSB   = 40;
  localparam int F_MODE_W     = 2;
  localparam int F_OPCODE_LSB = 36;
  localparam int F_OPCODE_W   = 4;
  localparam int F_OP_A_LSB   = 24;
  localparam int F_OP_B_LSB   = 12;
  localparam int F_OP_C_LSB   = 0;
  localparam int F_OPND_W     = 12;

  // Fetch FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// Program-counter and instruction-fetch stage in front of prog_mem.
// Drives the program address, captures the combinational line into an
// instruction register, folds unconditional jumps locally and hands
// instructions to execute over a valid/ready handshake.
//
// Ports:
//   clk            - system clock, rising edge
//   rst            - asynchronous, active-low reset
//   start          - one-cycle pulse that leaves IDLE
//   mem_addr       - address to prog_mem (equals pc)
//   mem_line       - combinational line returned by prog_mem
//   out_valid      - out_instr holds an instruction
//   out_ready      - execute stage accepts out_instr
//   out_instr      - registered instruction (addr field included)
//   redirect_valid - execute-stage request to restart fetch
//   redirect_addr  - target of the redirect
//   halted         - high in HALT
//   addr_err       - sticky: line addr field disagreed with pc on a capture
//   fetch_count    - completed handshakes, saturating
module fetch_unit
  import sincere_pkg::*;
#(
  parameter int ADDR_W     = 4,
  parameter int LINE_W     = 46,
  parameter int PROG_DEPTH = 7,
  parameter int RESET_PC   = 0,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [LINE_W-1:0] mem_line,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LINE_W-1:0] out_instr,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              halted,
  output logic              addr_err,
  output logic [CNT_W-1:0]  fetch_count
);

  localparam logic [ADDR_W-1:0] PC_RESET  = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] PC_LIMIT  = ADDR_W'(PROG_DEPTH);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  fetch_state_t      state;
  logic [ADDR_W-1:0] pc;

  logic              advance;
  logic [3:0]        line_opcode;
  logic [ADDR_W-1:0] line_addr;
  logic [ADDR_W-1:0] line_target;

  assign mem_addr    = pc;

  // No skid buffer: a new line may only be taken when the output register
  // is empty or is being drained this cycle.
  assign advance     = !out_valid || out_ready;

  assign line_opcode = mem_line[F_OPCODE_LSB +: F_OPCODE_W];
  assign line_addr   = mem_line[F_ADDR_LSB +: ADDR_W];
  assign line_target = mem_line[F_OP_A_LSB +: ADDR_W];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      pc          <= PC_RESET;
      out_valid   <= 1'b0;
      out_instr   <= '0;
      halted      <= 1'b0;
      addr_err    <= 1'b0;
      fetch_count <= '0;
    end else begin
      // Handshake counting is independent of the control path, so a
      // handshake in a redirect cycle is still counted.
      if (out_valid && out_ready && (fetch_count != CNT_MAX)) begin
        fetch_count <= fetch_count + 1'b1;
      end

      if (redirect_valid && (state != ST_IDLE)) begin
        // Flush whatever is held and restart from the target.
        pc        <= redirect_addr;
        out_valid <= 1'b0;
        state     <= ST_RUN;
        halted    <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              state <= ST_RUN;
            end
          end

          ST_RUN: begin
            if (advance) begin
              if (pc >= PC_LIMIT) begin
                state     <= ST_HALT;
                out_valid <= 1'b0;
                halted    <= 1'b1;
              end else begin
                if (line_addr != pc) begin
                  addr_err <= 1'b1;
                end
                if (line_opcode == OP_JMP) begin
                  // Jump is consumed here and leaves a one-cycle bubble.
                  pc        <= line_target;
                  out_valid <= 1'b0;
                end else begin
                  out_instr <= mem_line;
                  out_valid <= 1'b1;
                  pc        <= pc + 1'b1;
                end
              end
            end
          end

          ST_HALT: begin
            out_valid <= 1'b0;
            halted    <= 1'b1;
          end

          default: begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a combinational prog_mem model.
module tb_fetch_unit;
  import sincere_pkg::*;

  logic        clk;
  logic        rst;
  logic        start;
  logic [3:0]  mem_addr;
  logic [45:0] mem_line;
  logic        out_valid;
  logic        out_ready;
  logic [45:0] out_instr;
  logic        redirect_valid;
  logic [3:0]  redirect_addr;
  logic        halted;
  logic        addr_err;
  logic [15:0] fetch_count;

  logic [45:0] prog [16];

  int n_cmp = 0;
  int n_err = 0;

  assign mem_line = prog[mem_addr];

  fetch_unit dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .mem_addr      (mem_addr),
    .mem_line      (mem_line),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .redirect_valid(redirect_valid),
    .redirect_addr (redirect_addr),
    .halted        (halted),
    .addr_err      (addr_err),
    .fetch_count   (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [45:0] mk(input logic [3:0] a, input logic [3:0] op,
                                     input logic [11:0] x);
    return {a, 2'b00, op, x, 12'd0, 12'd0};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("check %-16s observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_prog;
    for (int i = 0; i < 16; i++) prog[i] = '0;
  endtask

  task automatic do_reset;
    rst = 1'b0;
    #3;
    rst = 1'b1;
    tick();
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; out_ready = 1'b1;
    redirect_valid = 1'b0; redirect_addr = 4'd0;

    // Toggle program: 0 MOV 150, 1 NOP, 2 NOT, 3 JMP 1
    clear_prog();
    prog[0] = mk(4'd0, OP_MOV, 12'd150);
    prog[1] = mk(4'd1, OP_NOP, 12'd0);
    prog[2] = mk(4'd2, OP_NOT, 12'd3);
    prog[3] = mk(4'd3, OP_JMP, 12'd1);

    #12;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_halted", 64'(halted), 64'd0);
    check("rst_count", 64'(fetch_count), 64'd0);
    check("rst_instr", 64'(out_instr), 64'd0);
    check("rst_addr_err", 64'(addr_err), 64'd0);
    check("rst_pc", 64'(mem_addr), 64'd0);
    rst = 1'b1;
    tick();

    pulse_start();
    check("start_nofetch_v", 64'(out_valid), 64'd0);
    check("start_nofetch_pc", 64'(mem_addr), 64'd0);

    // Expected: 0,1,2,bubble,1,2,bubble over 7 RUN edges
    tick(); check("tog_v0", 64'(out_valid), 64'd1); check("tog_a0", 64'(out_instr[45:42]), 64'd0);
    tick(); check("tog_v1", 64'(out_valid), 64'd1); check("tog_a1", 64'(out_instr[45:42]), 64'd1);
    tick(); check("tog_v2", 64'(out_valid), 64'd1); check("tog_a2", 64'(out_instr[45:42]), 64'd2);
    tick(); check("tog_bub1", 64'(out_valid), 64'd0); check("tog_jpc", 64'(mem_addr), 64'd1);
    tick(); check("tog_v4", 64'(out_valid), 64'd1); check("tog_a4", 64'(out_instr[45:42]), 64'd1);
    tick(); check("tog_v5", 64'(out_valid), 64'd1); check("tog_a5", 64'(out_instr[45:42]), 64'd2);
    check("tog_noJMP", 64'(out_instr[39:36] == OP_JMP), 64'd0);
    tick(); check("tog_bub2", 64'(out_valid), 64'd0);
    check("tog_count5", 64'(fetch_count), 64'd5);

    // Backpressure with addr 1 held
    tick(); check("bp_a1", 64'(out_instr[45:42]), 64'd1); check("bp_v", 64'(out_valid), 64'd1);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_hold_addr", 64'(out_instr[45:42]), 64'd1);
      check("bp_hold_pc", 64'(mem_addr), 64'd2);
      check("bp_hold_cnt", 64'(fetch_count), 64'd5);
      check("bp_hold_v", 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    tick();
    check("bp_rel_addr", 64'(out_instr[45:42]), 64'd2);
    check("bp_rel_cnt", 64'(fetch_count), 64'd6);

    // Redirect while holding an instruction under backpressure
    out_ready = 1'b0; redirect_valid = 1'b1; redirect_addr = 4'd0;
    tick();
    redirect_valid = 1'b0; out_ready = 1'b1;
    check("rd_valid", 64'(out_valid), 64'd0);
    check("rd_pc", 64'(mem_addr), 64'd0);
    check("rd_cnt", 64'(fetch_count), 64'd6);
    tick();
    check("rd_refetch", 64'(out_instr[45:42]), 64'd0);
    check("rd_cnt2", 64'(fetch_count), 64'd6);

    // Async reset mid-RUN
    #2; rst = 1'b0; #1;
    check("arst_valid", 64'(out_valid), 64'd0);
    check("arst_halted", 64'(halted), 64'd0);
    check("arst_count", 64'(fetch_count), 64'd0);
    check("arst_pc", 64'(mem_addr), 64'd0);
    rst = 1'b1;
    tick(); tick();
    check("arst_idle", 64'(out_valid), 64'd0);

    // Straight-line program of 7 entries, halt at pc 7
    clear_prog();
    prog[0] = mk(4'd0, OP_MOV, 12'd1);
    prog[1] = mk(4'd1, OP_ADD, 12'd2);
    prog[2] = mk(4'd2, OP_SUB, 12'd3);
    prog[3] = mk(4'd3, OP_MUL, 12'd4);
    prog[4] = mk(4'd4, OP_NOT, 12'd5);
    prog[5] = mk(4'd5, OP_NOP, 12'd6);
    prog[6] = mk(4'd6, OP_ADD, 12'd7);
    pulse_start();
    for (int i = 0; i < 7; i++) tick();
    check("sl_a6", 64'(out_instr[45:42]), 64'd6);
    check("sl_v6", 64'(out_valid), 64'd1);
    check("sl_nohalt", 64'(halted), 64'd0);
    tick();
    check("sl_halted", 64'(halted), 64'd1);
    check("sl_v_off", 64'(out_valid), 64'd0);
    check("sl_count", 64'(fetch_count), 64'd7);
    pulse_start();
    tick();
    check("sl_start_ign_h", 64'(halted), 64'd1);
    check("sl_start_ign_v", 64'(out_valid), 64'd0);

    // Redirect out of HALT
    redirect_valid = 1'b1; redirect_addr = 4'd0;
    tick();
    redirect_valid = 1'b0;
    check("rdh_halted", 64'(halted), 64'd0);
    check("rdh_pc", 64'(mem_addr), 64'd0);
    tick();
    check("rdh_fetch", 64'(out_valid), 64'd1);

    // Jump target out of range
    do_reset();
    clear_prog();
    prog[0] = mk(4'd0, OP_MOV, 12'd5);
    prog[1] = mk(4'd1, OP_JMP, 12'd9);
    pulse_start();
    tick(); check("jo_a0", 64'(out_instr[45:42]), 64'd0);
    tick(); check("jo_pc9", 64'(mem_addr), 64'd9); check("jo_nohalt", 64'(halted), 64'd0);
    tick(); check("jo_halt", 64'(halted), 64'd1);

    // Address mismatch sets sticky addr_err
    do_reset();
    clear_prog();
    prog[0] = mk(4'd5, OP_MOV, 12'd1);
    prog[1] = mk(4'd1, OP_NOP, 12'd0);
    pulse_start();
    check("ae_before", 64'(addr_err), 64'd0);
    tick();
    check("ae_set", 64'(addr_err), 64'd1);
    check("ae_processed", 64'(out_instr[45:42]), 64'd5);
    tick(); tick();
    check("ae_sticky", 64'(addr_err), 64'd1);
    rst = 1'b0; #1;
    check("ae_cleared", 64'(addr_err), 64'd0);
    rst = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Program-counter and instruction-fetch stage sitting directly upstream of prog_mem.
- Drives prog_mem's 4-bit addr and captures the returned 46-bit line into an instruction register.
- Folds unconditional jumps locally and presents instructions to the execute stage over a valid/ready handshake.
- Owns start, halt and redirect control of the instruction stream.

Parameters:
- ADDR_W, 4, program address width; must match prog_mem addr.
- LINE_W, 46, fetched line width: {addr[3:0], mode[1:0], opcode[3:0], op_a[11:0], op_b[11:0], op_c[11:0]}.
- PROG_DEPTH, 7, number of valid program entries; any address >= PROG_DEPTH is out of range.
- RESET_PC, 0, PC loaded on reset.
- CNT_W, 16, width of the delivered-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; leaves IDLE.
- mem_addr  out  ADDR_W  address to prog_mem; equals pc.
- mem_line  in  LINE_W  combinational line from prog_mem.
- out_valid  out  1  out_instr holds an instruction.
- out_ready  in  1  execute stage accepts out_instr.
- out_instr  out  LINE_W  registered instruction, addr field included.
- redirect_valid  in  1  execute-stage request to restart fetch.
- redirect_addr  in  ADDR_W  target of the redirect.
- halted  out  1  high in HALT state.
- addr_err  out  1  sticky; set when mem_line[45:42] != pc on a capture.
- fetch_count  out  CNT_W  handshakes completed, saturating.

Behaviour:
- Reset (rst=0, async): state=IDLE, pc=RESET_PC, out_valid=0, out_instr=0, halted=0, addr_err=0, fetch_count=0.
- mem_addr = pc, combinational. prog_mem is combinational, so a line is captured in the same cycle it is addressed.
- The "advance" condition is !out_valid || out_ready. There is no skid buffer.

- IDLE:
  - out_valid=0.
  - start=1 -> RUN. No fetch happens in the start cycle.

- RUN, on each clock edge where advance holds:
  - pc >= PROG_DEPTH: -> HALT, out_valid<=0, halted<=1.
  - Opcode mem_line[39:36] == 4'h2 (JUMP): pc <= op_a[ADDR_W-1:0], out_valid<=0. The jump is not forwarded and costs one bubble cycle.
  - Otherwise: out_instr<=mem_line, out_valid<=1, pc<=pc+1. pc wraps at 2^ADDR_W, but wrap is unreachable because PROG_DEPTH <= 15.
  - A jump whose target is >= PROG_DEPTH is accepted. HALT follows on the next advance.
  - Capture mismatch: if mem_line[45:42] != pc, set addr_err (sticky until reset). The instruction is still processed.

- RUN, when advance is false: pc, out_instr and out_valid hold.
- fetch_count increments on every cycle with out_valid && out_ready. It saturates at all-ones.

- HALT:
  - out_valid=0 and halted=1.
  - start is ignored.
  - Exited only by redirect or reset.

- Redirect:
  - Highest priority, in any state except IDLE.
  - Next cycle: pc<=redirect_addr, out_valid<=0 (the held instruction is flushed and not counted), state<=RUN, halted<=0.
  - A handshake in the redirect cycle itself still counts.
  - Redirect in IDLE is ignored.
- start while in RUN is ignored.
- Reset asserted mid-operation clears everything immediately. After release the block waits in IDLE for start.

Decomposition:
- Shared package sincere_pkg holds:
  - opcode constants: OP_NOP=0, OP_MOV=1, OP_JMP=2, OP_ADD=5, OP_SUB=6, OP_MUL=7, OP_NOT=8;
  - field bit offsets and widths for the 46-bit line;
  - fsm state encoding IDLE/RUN/HALT.
- No sub-module; a single module of roughly 150-200 lines.

Test Plan:
- Toggle program loaded in prog_mem (0: MOV 150, 1: NOP, 2: NOT, 3: JMP 1), out_ready=1, start pulse:
  - delivered addr sequence is 0,1,2, bubble, 1,2, bubble, ...;
  - opcode 2 never appears on out_instr;
  - fetch_count=5 after 7 RUN cycles.
- Backpressure: out_ready=0 for 3 cycles while out_instr addr=1:
  - out_instr, pc=2 and fetch_count are stable;
  - on release, addr 2 follows in the next cycle.
- Straight-line program with 7 non-jump entries and PROG_DEPTH=7:
  - after addr 6 is accepted, halted=1 and out_valid=0 on the next edge;
  - start is then ignored.
- Jump target out of range (JMP 9): halted rises one advance after the jump is captured.
- redirect_valid with redirect_addr=0 while out_valid=1 and out_ready=0:
  - next cycle out_valid=0 and pc=0;
  - the held instruction is never counted;
  - from HALT, the same redirect clears halted.
- Reset edge cases:
  - drive rst low asynchronously mid-RUN: out_valid, halted and fetch_count are 0 before the next clk edge;
  - force a prog_mem line whose addr field differs from pc: addr_err=1 and stays set until reset.
